// File: rtl/matrix_scan_animator.sv
// matrix_scan_animator: row-scans a ROWS x COLS LED matrix from a writable animated sprite memory
// Ports: clk/rst (sync, active-high); en scan enable; anim_en animation advance enable;
//   sprite_sel requested sprite (latched per scan); wr_en/wr_addr/wr_data sprite memory write;
//   row_n one-cold active-low row select; col active-high column data;
//   frame_idx current animation frame; frame_start first-cycle-of-scan pulse.
module matrix_scan_animator #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int SPRITES = 4,
  parameter int FRAMES = 2,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK = 8,
  parameter int ANIM_SCANS = 50,
  localparam int DEPTH = SPRITES * FRAMES * ROWS,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int SW = SPRITES > 1 ? $clog2(SPRITES) : 1,
  localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            anim_en,
  input  logic [SW-1:0]   sprite_sel,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col,
  output logic [FW-1:0]   frame_idx,
  output logic            frame_start
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int CW = ANIM_SCANS > 1 ? $clog2(ANIM_SCANS) : 1;
  logic [COLS-1:0] mem [DEPTH];
  logic [COLS-1:0] rd;
  logic [DW-1:0] div_cnt;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] scan_cnt;
  logic [SW-1:0] sprite_q, sel_ok, sprite_eff;
  logic [AW-1:0] rd_addr;
  logic div_last, row_last, scan_last, wrap, wr_ok, adv, drive;
  // Counter state in cycle s describes the output in cycle s+1.
  always_comb begin
    div_last = div_cnt == DW'(SCAN_DIV - 1);
    row_last = row_idx == RW'(ROWS - 1);
    scan_last = scan_cnt == CW'(ANIM_SCANS - 1);
    wrap = en && div_last && row_last;
    wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
    sel_ok = {1'b0, sprite_sel} < (SW + 1)'(SPRITES) ? sprite_sel : '0;
    // The latch loads while frame_start is shown; bypass it so a row-0 read in that cycle sees the new sprite.
    sprite_eff = frame_start ? sel_ok : sprite_q;
    rd_addr = AW'((int'(sprite_eff) * FRAMES + int'(frame_idx)) * ROWS + int'(row_idx));
    col = drive ? rd : '0;
  end
  // One read per row slot, at the first driven cycle, so a write later in the slot cannot tear it.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (div_cnt == DW'(BLANK)) rd <= mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      row_idx <= '0;
      scan_cnt <= '0;
      sprite_q <= '0;
      frame_idx <= '0;
      frame_start <= 1'b0;
      adv <= 1'b0;
      drive <= 1'b0;
      row_n <= '1;
    end else begin
      div_cnt <= (!en || div_last) ? '0 : div_cnt + 1'b1;
      row_idx <= !en ? '0 : div_last ? (row_last ? '0 : row_idx + 1'b1) : row_idx;
      scan_cnt <= !en ? '0 : (wrap && anim_en) ? (scan_last ? '0 : scan_cnt + 1'b1) : scan_cnt;
      // Frame advance is deferred one cycle so it lands together with frame_start.
      adv <= wrap && anim_en && scan_last;
      if (en && adv) frame_idx <= frame_idx == FW'(FRAMES - 1) ? '0 : frame_idx + 1'b1;
      frame_start <= en && div_cnt == '0 && row_idx == '0;
      sprite_q <= sprite_eff;
      drive <= en && div_cnt >= DW'(BLANK);
      row_n <= (en && div_cnt >= DW'(BLANK)) ? ~(ROWS'(1) << (ROWS - 1 - int'(row_idx))) : '1;
    end
  end
endmodule

// File: doc/matrix_scan_animator.md
Name: matrix_scan_animator

Overview:
Parametrised successor to the 8x8 direction/character matrix driver. It row-scans a ROWS x COLS LED matrix from an internal writable sprite memory that holds SPRITES sprites of FRAMES animation frames each. It steps animation frames on a programmable refresh count and inserts anti-ghost blanking at every row change. Sprite selection is tear-free, so a change only takes effect at a scan boundary.

Parameters:
ROWS, 8, matrix rows (>=2)
COLS, 8, matrix columns (>=1)
SPRITES, 4, number of sprites (e.g. one per direction)
FRAMES, 2, animation frames per sprite (>=1)
SCAN_DIV, 1000, clk cycles per row slot (>=2)
BLANK, 8, blanked cycles at the start of each row slot (1 <= BLANK < SCAN_DIV)
ANIM_SCANS, 50, complete scans per animation frame (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  scan enable
anim_en  in  1  animation advance enable
sprite_sel  in  max(1,$clog2(SPRITES))  requested sprite
wr_en  in  1  sprite memory write strobe
wr_addr  in  AW=$clog2(SPRITES*FRAMES*ROWS)  write word address
wr_data  in  COLS  row bitmap, 1 = LED on
row_n  out  ROWS  row select, active-low, one-cold
col  out  COLS  column data, active-high
frame_idx  out  max(1,$clog2(FRAMES))  current animation frame
frame_start  out  1  one-cycle pulse on the first cycle of each scan

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: row_n all ones, col 0, frame_idx 0, frame_start 0. All counters are cleared and the latched sprite is 0. Sprite memory is not reset.
- Memory:
  - Depth SPRITES*FRAMES*ROWS, word COLS bits.
  - Word address = (sprite*FRAMES + frame)*ROWS + row.
  - A write with wr_en=1 and wr_addr >= depth is ignored.
  - Writes are accepted regardless of en.
  - Read is registered, read-before-write: a same-cycle write/read to one address returns the old word.
- Counters:
  - div_cnt runs 0..SCAN_DIV-1.
  - row_idx increments when div_cnt wraps and wraps at ROWS-1 -> 0.
  - scan_cnt counts completed scans, 0..ANIM_SCANS-1.
- Slot timing, measured at the outputs; the cycle numbering starts at the first output cycle of the slot:
  - Slot cycles 0..BLANK-1: row_n all ones, col 0.
  - Slot cycles BLANK..SCAN_DIV-1: row r drives row_n bit (ROWS-1-r) low and all other bits high; col = mem[addr(r)].
  - A full scan therefore lasts ROWS*SCAN_DIV cycles.
- Sprite latch: sprite_sel is sampled on the first cycle of each scan, coincident with frame_start, and is held for the whole scan.
- sprite_sel >= SPRITES: latch 0.
- Animation:
  - When a scan completes with anim_en=1, scan_cnt increments.
  - On reaching ANIM_SCANS, scan_cnt clears and frame_idx advances (FRAMES-1 -> 0).
  - The new frame_idx is visible from the first cycle of the next scan, together with frame_start.
  - anim_en=0: scan_cnt and frame_idx hold.
  - FRAMES=1: frame_idx is constant 0.
- en=0:
  - The next output cycle is blank (row_n all ones, col 0).
  - div_cnt, row_idx and scan_cnt clear; frame_idx holds.
  - When en returns to 1, the scan restarts at row 0 slot cycle 0, and frame_start pulses.
- rst mid-operation overrides everything and returns to the reset values. It takes effect on the next cycle.
- frame_start pulses exactly once per ROWS*SCAN_DIV cycles while en=1. It never pulses while en=0.

Test Plan:
Bench parameters for all scenarios: ROWS=4, COLS=4, SPRITES=3, FRAMES=2, SCAN_DIV=6, BLANK=2, ANIM_SCANS=3. Memory depth is 24, AW=5.
1. Reset: rst=1 for 3 cycles with en=1 -> row_n=4'b1111, col=0, frame_idx=0, frame_start=0 on every cycle.
2. Basic scan: load mem[a]=a[3:0] for a=0..23; en=1, anim_en=0, sprite_sel=0.
   - Row 0 slot: 2 cycles blank, then 4 cycles of row_n=4'b0111, col=4'h0.
   - Row 1 slot: row_n=4'b1011, col=4'h1.
   - frame_start pulses every 24 cycles.
3. Animation: anim_en=1 -> frame_idx goes 0->1 at the start of scan 4 (72 cycles after the first frame_start) and back to 0 at 144. In frame 1, row 0 shows col=4'h4.
4. Tear-free select: sprite_sel changes 0->1 during the row-2 slot -> rows 2 and 3 still show 4'h2 and 4'h3. The next scan (frame 0) shows 4'h8..4'hB.
5. Writes:
   - Write mem[1]=4'hF during the row-1 drive phase -> the current slot keeps 4'h1; the next scan shows 4'hF.
   - wr_addr=25 with wr_data=4'h7 -> no location changes.
6. Enable and reset interruption:
   - Drop en during row 2 -> the next cycle is blank and frame_idx is held. Raise en -> frame_start pulses and row 0 blanking restarts.
   - Repeat with rst=1 -> same restart, with frame_idx=0.
